// File: rtl/pi_loop_filter_geared.sv
// pi_loop_filter_geared: two-stage geared PI loop filter driving the ADPLL DCO.
// Define LF_ANTIWINDUP_EN to hold the integrator while the output is pinned on a rail.
module pi_loop_filter_geared #(
  parameter int ERROR_WIDTH   = 8,
  parameter int DCO_CC_WIDTH  = 9,
  parameter int KP_WIDTH      = 4,
  parameter int KP_FRAC_WIDTH = 2,
  parameter int KI_WIDTH      = 6,
  parameter int KI_FRAC_WIDTH = 5,
  parameter int ACC_GUARD     = 4,
  parameter int LOCK_THRESH   = 2,
  parameter int UNLOCK_THRESH = 8,
  parameter int LOCK_COUNT    = 16
) (
  input  logic                           gen_clk_i,
  input  logic                           reset_n_i,
  input  logic                           clear_i,
  input  logic [KP_WIDTH-1:0]            kp_acq_i,
  input  logic [KI_WIDTH-1:0]            ki_acq_i,
  input  logic [KP_WIDTH-1:0]            kp_trk_i,
  input  logic [KI_WIDTH-1:0]            ki_trk_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_i,
  input  logic                           error_valid_i,
  output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
  output logic                           dco_cc_valid_o,
  output logic                           locked_o,
  output logic                           sat_o
);

  localparam int PW   = ERROR_WIDTH + KP_WIDTH;
  localparam int IW   = ERROR_WIDTH + KI_WIDTH;
  localparam int AW   = IW + ACC_GUARD;
  localparam int SW   = AW + 2;
  localparam int SH   = KI_FRAC_WIDTH - KP_FRAC_WIDTH;
  localparam int CNTW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int EW1  = ERROR_WIDTH + 1;

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [AW:0]   ACC_MAX_X = (AW+1)'(ACC_MAX);
  localparam logic signed [AW:0]   ACC_MIN_X = (AW+1)'(ACC_MIN);
  localparam logic signed [SW-1:0] HALF = SW'(2 ** (KI_FRAC_WIDTH - 1));
  localparam logic signed [SW-1:0] CC_MAX = SW'((2 ** (DCO_CC_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] CC_MIN = ~CC_MAX;
  localparam logic [CNTW-1:0]      CNT_LAST = CNTW'(LOCK_COUNT - 1);

  typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

  state_t                 state;
  logic [CNTW-1:0]        cnt;
  logic                   s1_valid;
  logic signed [PW-1:0]   s1_p;
  logic signed [IW-1:0]   s1_i;
  logic signed [AW-1:0]   acc;

  logic [KP_WIDTH-1:0]    kp_sel;
  logic [KI_WIDTH-1:0]    ki_sel;
  logic signed [PW-1:0]   p_mul;
  logic signed [IW-1:0]   i_mul;
  logic [EW1-1:0]         err_ext;
  logic [EW1-1:0]         err_abs;
  logic                   in_lock;
  logic                   out_lock;

  logic signed [AW:0]     acc_sum;
  logic signed [AW-1:0]   acc_int;
  logic signed [AW-1:0]   acc_next;
  logic signed [SW-1:0]   r_out;
  logic [DCO_CC_WIDTH-1:0] cc_next;
  logic                   sat_next;

  function automatic logic signed [SW-1:0] round_sum(
    input logic signed [PW-1:0] p,
    input logic signed [AW-1:0] a
  );
    logic signed [SW-1:0] s;
    s = (SW'(p) <<< SH) + SW'(a) + HALF;
    return s >>> KI_FRAC_WIDTH;
  endfunction

  assign kp_sel = (state == TRACK) ? kp_trk_i : kp_acq_i;
  assign ki_sel = (state == TRACK) ? ki_trk_i : ki_acq_i;
  assign p_mul  = PW'(error_i) * $signed(PW'(kp_sel));
  assign i_mul  = IW'(error_i) * $signed(IW'(ki_sel));

  // One extra bit so that -2^(ERROR_WIDTH-1) has a representable magnitude
  assign err_ext  = {error_i[ERROR_WIDTH-1], error_i};
  assign err_abs  = error_i[ERROR_WIDTH-1] ? (~err_ext + 1'b1) : err_ext;
  assign in_lock  = err_abs <= EW1'(LOCK_THRESH);
  assign out_lock = err_abs > EW1'(UNLOCK_THRESH);

  always_comb begin
    acc_sum = (AW+1)'(acc) + (AW+1)'(s1_i);
    acc_int = acc_sum[AW-1:0];
    if (acc_sum > ACC_MAX_X)
      acc_int = ACC_MAX;
    else if (acc_sum < ACC_MIN_X)
      acc_int = ACC_MIN;
  end

`ifdef LF_ANTIWINDUP_EN
  logic signed [SW-1:0] r_int;
  logic                 hold;

  assign r_int = round_sum(s1_p, acc_int);
  assign hold  = ((r_int > CC_MAX) && !s1_i[IW-1] && (s1_i != '0)) ||
                 ((r_int < CC_MIN) && s1_i[IW-1]);
  assign acc_next = hold ? acc : acc_int;
`else
  assign acc_next = acc_int;
`endif

  always_comb begin
    r_out    = round_sum(s1_p, acc_next);
    cc_next  = r_out[DCO_CC_WIDTH-1:0];
    sat_next = 1'b0;
    if (r_out > CC_MAX) begin
      cc_next  = CC_MAX[DCO_CC_WIDTH-1:0];
      sat_next = 1'b1;
    end else if (r_out < CC_MIN) begin
      cc_next  = CC_MIN[DCO_CC_WIDTH-1:0];
      sat_next = 1'b1;
    end
  end

  assign locked_o = (state == TRACK);

  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= ACQ;
      cnt            <= '0;
      s1_valid       <= 1'b0;
      s1_p           <= '0;
      s1_i           <= '0;
      acc            <= '0;
      dco_cc_o       <= '0;
      dco_cc_valid_o <= 1'b0;
      sat_o          <= 1'b0;
    end else if (clear_i) begin
      state          <= ACQ;
      cnt            <= '0;
      s1_valid       <= 1'b0;
      s1_p           <= '0;
      s1_i           <= '0;
      acc            <= '0;
      dco_cc_valid_o <= 1'b0;
      sat_o          <= 1'b0;
    end else begin
      s1_valid       <= error_valid_i;
      dco_cc_valid_o <= s1_valid;
      if (error_valid_i) begin
        s1_p <= p_mul;
        s1_i <= i_mul;
        unique case (state)
          ACQ: begin
            if (!in_lock) cnt <= '0;
            else if (cnt == CNT_LAST) begin
              state <= TRACK;
              cnt   <= '0;
            end else cnt <= cnt + CNTW'(1);
          end
          TRACK: begin
            if (!out_lock) cnt <= '0;
            else if (cnt == CNT_LAST) begin
              state <= ACQ;
              cnt   <= '0;
            end else cnt <= cnt + CNTW'(1);
          end
        endcase
      end
      if (s1_valid) begin
        acc      <= acc_next;
        dco_cc_o <= cc_next;
        sat_o    <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_pi_loop_filter_geared.sv
// tb_pi_loop_filter_geared: directed vector table plus lock, clear and reset sequences.
// Expected codes are hand-computed from the fixed-point formats.
module tb_pi_loop_filter_geared;

  logic              gen_clk_i = 1'b0;
  logic              reset_n_i;
  logic              clear_i;
  logic [3:0]        kp_acq_i, kp_trk_i;
  logic [5:0]        ki_acq_i, ki_trk_i;
  logic signed [7:0] error_i;
  logic              error_valid_i;
  logic signed [8:0] dco_cc_o;
  logic              dco_cc_valid_o;
  logic              locked_o;
  logic              sat_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef LF_ANTIWINDUP_EN
  localparam int L_EXP = -4;
`else
  localparam int L_EXP = 12;
`endif

  pi_loop_filter_geared dut (
    .gen_clk_i      (gen_clk_i),
    .reset_n_i      (reset_n_i),
    .clear_i        (clear_i),
    .kp_acq_i       (kp_acq_i),
    .ki_acq_i       (ki_acq_i),
    .kp_trk_i       (kp_trk_i),
    .ki_trk_i       (ki_trk_i),
    .error_i        (error_i),
    .error_valid_i  (error_valid_i),
    .dco_cc_o       (dco_cc_o),
    .dco_cc_valid_o (dco_cc_valid_o),
    .locked_o       (locked_o),
    .sat_o          (sat_o)
  );

  always #5 gen_clk_i = ~gen_clk_i;

  typedef struct {
    logic signed [7:0] e;
    logic              v;
    logic              c;
    logic [3:0]        kp;
    logic [5:0]        ki;
    logic              ev;
    int                edco;
    logic              esat;
    logic              elk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int e, input int v, input int c, input int kp,
                     input int ki, input int ev, input int edco,
                     input int esat, input int elk);
    vec_t t;
    t.e    = 8'(e);
    t.v    = v[0];
    t.c    = c[0];
    t.kp   = 4'(kp);
    t.ki   = 6'(ki);
    t.ev   = ev[0];
    t.edco = edco;
    t.esat = esat[0];
    t.elk  = elk[0];
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int e, input logic v, input logic c);
    error_i       = 8'(e);
    error_valid_i = v;
    clear_i       = c;
    @(posedge gen_clk_i);
    #1;
  endtask

  task automatic chk_all(input string nm, input int ev, input int edco,
                         input int esat, input int elk);
    chk({nm, " valid"}, int'(dco_cc_valid_o), ev);
    chk({nm, " dco"}, int'(dco_cc_o), edco);
    chk({nm, " sat"}, int'(sat_o), esat);
    chk({nm, " locked"}, int'(locked_o), elk);
  endtask

  initial begin
    reset_n_i     = 1'b0;
    clear_i       = 1'b0;
    error_i       = '0;
    error_valid_i = 1'b0;
    kp_acq_i      = 4'd4;
    ki_acq_i      = 6'd4;
    kp_trk_i      = 4'd4;
    ki_trk_i      = 6'd4;
    #17;
    chk_all("reset", 0, 0, 0, 0);
    reset_n_i = 1'b1;

    //   e    v  c  kp  ki  | ev  dco  sat lk
    add(   8, 1, 0,  4,  4,   0,    0, 0, 0);
    add(   8, 1, 0,  4,  4,   1,    9, 0, 0);
    add(   8, 1, 0,  4,  4,   1,   10, 0, 0);
    add(   0, 0, 0,  4,  4,   1,   11, 0, 0);
    add(   0, 0, 0,  4,  4,   0,   11, 0, 0);
    add(   0, 0, 1,  4,  4,   0,   11, 0, 0);
    add(   1, 1, 0,  0,  4,   0,   11, 0, 0);
    add(   1, 1, 0,  0,  4,   1,    0, 0, 0);
    add(   1, 1, 0,  0,  4,   1,    0, 0, 0);
    add(   1, 1, 0,  0,  4,   1,    0, 0, 0);
    add(   0, 0, 0,  0,  4,   1,    1, 0, 0);
    add(   0, 0, 1,  4,  4,   0,    1, 0, 0);
    add( 127, 1, 0, 15,  4,   0,    1, 0, 0);
    add(   0, 0, 0, 15,  4,   1,  255, 1, 0);
    add(  -1, 1, 0, 15,  4,   0,  255, 1, 0);
    add(  -1, 1, 0, 15,  4,   1, L_EXP, 0, 0);
    add(   0, 0, 0, 15,  4,   1, L_EXP, 0, 0);
    add(   0, 0, 1,  4,  4,   0, L_EXP, 0, 0);
    add(  -8, 1, 0,  4,  4,   0, L_EXP, 0, 0);
    add(   0, 0, 0,  4,  4,   1,   -9, 0, 0);
    add(   0, 0, 1, 15, 63,   0,   -9, 0, 0);
    add(-128, 1, 0, 15, 63,   0,   -9, 0, 0);
    add(   0, 0, 0, 15, 63,   1, -256, 1, 0);
    add(   0, 0, 1,  4,  4,   0, -256, 0, 0);

    foreach (tbl[i]) begin
      kp_acq_i = tbl[i].kp;
      ki_acq_i = tbl[i].ki;
      cyc(int'(tbl[i].e), tbl[i].v, tbl[i].c);
      chk_all($sformatf("vec%0d", i), int'(tbl[i].ev), tbl[i].edco,
              int'(tbl[i].esat), int'(tbl[i].elk));
    end

    // Lock after exactly 16 in-lock samples, then tracking kp=2.0
    kp_acq_i = 4'd4;
    ki_acq_i = 6'd4;
    kp_trk_i = 4'd8;
    ki_trk_i = 6'd4;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1'b1, 1'b0);
      if (i == 14) chk("lock after 15", int'(locked_o), 0);
      if (i == 15) chk("lock after 16", int'(locked_o), 1);
    end
    cyc(4, 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b0);
    chk("trk gain valid", int'(dco_cc_valid_o), 1);
    chk("trk gain dco", int'(dco_cc_o), 9);

    for (int i = 0; i < 15; i++) cyc(20, 1'b1, 1'b0);
    cyc(0, 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b0);
    chk("broken run stays locked", int'(locked_o), 1);

    for (int i = 0; i < 16; i++) begin
      cyc(20, 1'b1, 1'b0);
      if (i == 14) chk("unlock after 15", int'(locked_o), 1);
      if (i == 15) chk("unlock after 16", int'(locked_o), 0);
    end

    for (int i = 0; i < 16; i++) cyc(0, 1'b1, 1'b0);
    chk("relock", int'(locked_o), 1);

    // Clear coincident with a sample in the middle of a step
    cyc(8, 1'b1, 1'b0);
    cyc(8, 1'b1, 1'b1);
    chk("clear kills pulse A", int'(dco_cc_valid_o), 0);
    chk("clear locked", int'(locked_o), 0);
    chk("clear sat", int'(sat_o), 0);
    cyc(0, 1'b0, 1'b0);
    chk("clear drops sample B", int'(dco_cc_valid_o), 0);
    cyc(8, 1'b1, 1'b0);
    cyc(0, 1'b0, 1'b0);
    chk("post-clear valid", int'(dco_cc_valid_o), 1);
    chk("post-clear dco", int'(dco_cc_o), 9);

    // Asynchronous reset between clock edges
    #2;
    reset_n_i = 1'b0;
    #1;
    chk_all("async reset", 0, 0, 0, 0);
    #10;
    reset_n_i = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
